// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter: CPU stores feed a small byte FIFO that an
// 8N1 serializer drains onto txd; a status register reports busy/full/overflow.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_FF00,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_FF04,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               hit,
  output logic               txd,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;

  logic [1:0]         r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_txd;

  logic               w_tx_sel;
  logic               w_status_sel;
  logic               w_full;
  logic               w_busy;
  logic               w_push;
  logic               w_drop;
  logic               w_clear;
  logic               w_pop;
  logic               w_baud_last;
  logic [7:0]         w_head;
  logic               w_unused_wdata;

  assign w_tx_sel     = (addr == TX_ADDR);
  assign w_status_sel = (addr == STATUS_ADDR);
  assign w_full       = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_busy       = (r_state != IDLE) || (r_count != '0);
  // full is the pre-edge value, so a pop on the same edge cannot rescue a push
  assign w_push       = we && w_tx_sel && !w_full;
  assign w_drop       = we && w_tx_sel && w_full;
  assign w_clear      = we && w_status_sel && wdata[2];
  assign w_baud_last  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_pop        = (r_count != '0) &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));
  assign w_head       = r_mem[r_rd_ptr];
  assign w_unused_wdata = ^wdata[31:8];

  assign hit        = w_tx_sel || w_status_sel;
  assign txd        = r_txd;
  assign fifo_count = r_count;

  always_comb begin
    // NOTE: assign a default before any condition so no path leaves rdata unassigned (no latch).
    rdata = '0;
    if (w_status_sel) rdata = {29'b0, r_overflow, w_full, w_busy};
  end

  // NOTE: storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overflow <= 1'b1;
      else if (w_clear) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= START;
            r_shift <= w_head;
            r_txd   <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
          end
        end
        START: begin
          if (w_baud_last) begin
            r_state <= DATA;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_baud  <= '0;
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
              r_bit   <= '0;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            r_bit  <= '0;
            // back-to-back frames: the next start bit follows the stop bit directly
            if (w_pop) begin
              r_state <= START;
              r_shift <= w_head;
              r_txd   <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_AW=3).
module tb_mmio_uart_tx;

  localparam logic [31:0] TX_ADDR     = 32'h0000_FF00;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_FF04;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        txd;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx #(
    .TX_ADDR      (TX_ADDR),
    .STATUS_ADDR  (STATUS_ADDR),
    .CLKS_PER_BIT (4),
    .FIFO_AW      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .hit        (hit),
    .txd        (txd),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected 40-sample line image of one 8N1 frame at 4 clocks per bit.
  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [39:0] f;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       f[k] = 1'b0;
      else if (k < 36) f[k] = b[(k - 4) / 4];
      else             f[k] = 1'b1;
    end
    return f;
  endfunction

  // Wait (bounded) for a start bit, then record txd on each of the 40 frame clocks.
  task automatic recv_frame(output logic [39:0] f, output int gap, output logic busy_last);
    gap       = 0;
    f         = '1;
    busy_last = 1'b0;
    while (txd !== 1'b0 && gap < 200) begin
      tick();
      gap++;
    end
    if (txd === 1'b0) begin
      for (int k = 0; k < 40; k++) begin
        f[k] = txd;
        if (k == 39) busy_last = rdata[0];
        tick();
      end
    end
  endtask

  task automatic watch_idle(input int n, output int lows);
    lows = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
  endtask

  logic [39:0] frames [9];
  int          gaps   [9];
  logic        busy_last;
  int          lows;
  int          peak;
  logic [7:0]  burst [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;

    // 1. reset state and address decode
    tick(); tick();
    rst = 1'b0;
    check("rst_txd", txd, 1);
    check("rst_count", fifo_count, 0);
    addr = STATUS_ADDR; #1;
    check("rst_status", rdata, 0);
    check("hit_status", hit, 1);
    addr = TX_ADDR; #1;
    check("hit_tx", hit, 1);
    addr = 32'h0000_0100; #1;
    check("hit_other", hit, 0);

    // 2. single byte 0xA5
    we = 1'b1; addr = TX_ADDR; wdata = 32'h0000_00A5;
    tick();
    we = 1'b0; addr = STATUS_ADDR; #1;
    check("single_count", fifo_count, 1);
    check("single_txd_idle", txd, 1);
    check("single_busy", rdata, 1);
    recv_frame(frames[0], gaps[0], busy_last);
    check("single_latency", gaps[0], 1);
    check("single_frame", frames[0], frame_of(8'hA5));
    check("single_busy_last", busy_last, 1);
    check("single_busy_drop", rdata, 0);

    // 3. ten back-to-back stores; the tenth finds the FIFO full
    peak = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          we = 1'b1; addr = TX_ADDR; wdata = 32'(i);
          tick();
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        we = 1'b0;
      end
      begin
        for (int j = 0; j < 9; j++) recv_frame(frames[j], gaps[j], busy_last);
      end
    join
    check("burst_peak", peak, 8);
    check("burst_gap0", gaps[0], 2);
    for (int j = 0; j < 9; j++) begin
      check($sformatf("burst_frame%0d", j), frames[j], frame_of(8'(j)));
      if (j > 0) check($sformatf("burst_gap%0d", j), gaps[j], 0);
    end
    addr = STATUS_ADDR; #1;
    check("burst_status", rdata, 4);
    watch_idle(60, lows);
    check("burst_no_extra", lows, 0);

    // 4. overflow clear; a status write without bit2 leaves it set
    we = 1'b1; addr = STATUS_ADDR; wdata = 32'hFFFF_FFFB;
    tick();
    we = 1'b0; #1;
    check("ovf_keep", rdata, 4);
    we = 1'b1; wdata = 32'h0000_0000;
    tick();
    we = 1'b0; #1;
    check("ovf_keep_zero", rdata, 4);
    we = 1'b1; wdata = 32'h0000_0004;
    tick();
    we = 1'b0; #1;
    check("ovf_clear", rdata, 0);

    // 5. reset in DATA bit3 of 0x11 with 3 bytes queued
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = TX_ADDR; wdata = {24'h0, burst[i]};
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("abort_pre_txd", txd, 0);
    check("abort_pre_count", fifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_txd", txd, 1);
    check("abort_count", fifo_count, 0);
    addr = STATUS_ADDR; #1;
    check("abort_status", rdata, 0);
    watch_idle(100, lows);
    check("abort_no_frames", lows, 0);

    // 6. writes to unmapped addresses
    we = 1'b1; addr = 32'h0000_FF08; wdata = 32'h0000_0055; #1;
    check("ff08_hit", hit, 0);
    check("ff08_rdata", rdata, 0);
    tick();
    check("ff08_count", fifo_count, 0);
    addr = 32'h0000_0000; #1;
    check("zero_hit", hit, 0);
    check("zero_rdata", rdata, 0);
    tick();
    we = 1'b0;
    check("zero_count", fifo_count, 0);
    watch_idle(20, lows);
    check("unmapped_idle", lows, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
